// File: rtl/icache.sv
// Direct-mapped, read-only instruction cache with single-word refill and hit/miss counters.
// Hits are combinational; a miss latches its address and refills over the iREN/iwait handshake.
module icache #(
  parameter int unsigned IDX_W = 4,
  parameter int unsigned TAG_W = 26
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        imemREN,
  input  logic [31:0] imemaddr,
  input  logic        halt,
  output logic        ihit,
  output logic [31:0] imemload,
  output logic        iREN,
  output logic [31:0] iaddr,
  input  logic        iwait,
  input  logic [31:0] iload,
  output logic [31:0] hit_count,
  output logic [31:0] miss_count
);

  localparam int unsigned FRAMES = 1 << IDX_W;

  typedef enum logic {IDLE, FETCH} state_t;

  state_t state, state_next;

  logic             valid [FRAMES];
  logic [TAG_W-1:0] tags  [FRAMES];
  logic [31:0]      data  [FRAMES];

  // Word address of the outstanding miss; byte offset is never needed.
  logic [31:2]      miss_addr;

  logic [IDX_W-1:0] idx, miss_idx;
  logic [TAG_W-1:0] tag, miss_tag;
  logic             hit, start_miss, fill;
  logic             unused_addr_bits;

  assign idx              = imemaddr[IDX_W+1:2];
  assign tag              = imemaddr[31:IDX_W+2];
  assign miss_idx         = miss_addr[IDX_W+1:2];
  assign miss_tag         = miss_addr[31:IDX_W+2];
  assign unused_addr_bits = ^imemaddr[1:0];

  assign hit      = imemREN && !halt && (state == IDLE) && valid[idx] && (tags[idx] == tag);
  assign ihit     = hit;
  assign imemload = hit ? data[idx] : '0;
  assign iREN     = (state == FETCH);
  assign iaddr    = (state == FETCH) ? {miss_addr, 2'b00} : '0;

  always_comb begin
    state_next = state;
    start_miss = 1'b0;
    fill       = 1'b0;
    unique case (state)
      IDLE: begin
        if (imemREN && !halt && !hit) begin
          start_miss = 1'b1;
          state_next = FETCH;
        end
      end
      FETCH: begin
        if (!iwait) begin
          fill       = 1'b1;
          state_next = IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state      <= IDLE;
      miss_addr  <= '0;
      hit_count  <= '0;
      miss_count <= '0;
    end else begin
      state <= state_next;
      if (start_miss) begin
        miss_addr <= imemaddr[31:2];
        if (miss_count != '1) miss_count <= miss_count + 32'd1;
      end
      if (hit && hit_count != '1) hit_count <= hit_count + 32'd1;
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      for (int unsigned i = 0; i < FRAMES; i++) begin
        valid[i] <= 1'b0;
        tags[i]  <= '0;
        data[i]  <= '0;
      end
    end else if (fill) begin
      valid[miss_idx] <= 1'b1;
      tags[miss_idx]  <= miss_tag;
      data[miss_idx]  <= iload;
    end
  end

endmodule

// File: tb/tb_icache.sv
// Directed bench for icache: a small memory responder feeds refills, and a scoreboard
// queue holds the instruction each accepted fetch must return when ihit rises.
module tb_icache;

  logic        CLK = 1'b0;
  logic        nRST;
  logic        imemREN;
  logic [31:0] imemaddr;
  logic        halt;
  logic        ihit;
  logic [31:0] imemload;
  logic        iREN;
  logic [31:0] iaddr;
  logic        iwait;
  logic [31:0] iload;
  logic [31:0] hit_count;
  logic [31:0] miss_count;

  int unsigned checks = 0;
  int unsigned errors = 0;
  logic [31:0] sb[$];
  logic [31:0] exp_hit  = '0;
  logic [31:0] exp_miss = '0;

  icache #(.IDX_W(4), .TAG_W(26)) dut (
    .CLK(CLK), .nRST(nRST), .imemREN(imemREN), .imemaddr(imemaddr), .halt(halt),
    .ihit(ihit), .imemload(imemload), .iREN(iREN), .iaddr(iaddr), .iwait(iwait),
    .iload(iload), .hit_count(hit_count), .miss_count(miss_count)
  );

  always #5 CLK = ~CLK;

  function automatic logic [31:0] memword(input logic [31:0] a);
    if (a == 32'h0000_0040) return 32'h2001_0005;
    return (a ^ 32'hA5A5_0000) + 32'h0000_0013;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_counts(input string tag);
    chk({tag, "_hits"}, hit_count, exp_hit);
    chk({tag, "_misses"}, miss_count, exp_miss);
  endtask

  // Called just after a rising edge; returns just after the edge that ends the hit cycle.
  task automatic fetch(input logic [31:0] a, input bit miss, input int unsigned nwait);
    logic [31:0] exp;
    imemREN = 1'b1; imemaddr = a; halt = 1'b0; iwait = 1'b1;
    sb.push_back(memword({a[31:2], 2'b00}));
    if (miss) begin
      @(negedge CLK);
      chk("detect_ihit", {31'b0, ihit}, 32'd0);
      chk("detect_iren", {31'b0, iREN}, 32'd0);
      @(posedge CLK); #1;
      for (int i = 0; i <= int'(nwait); i++) begin
        iwait = (i < int'(nwait));
        iload = iwait ? 32'hDEAD_BEEF : memword(iaddr);
        @(negedge CLK);
        chk("fetch_iren", {31'b0, iREN}, 32'd1);
        chk("fetch_iaddr", iaddr, {a[31:2], 2'b00});
        chk("fetch_ihit", {31'b0, ihit}, 32'd0);
        @(posedge CLK); #1;
      end
      iwait = 1'b1;
      exp_miss++;
    end
    @(negedge CLK);
    chk("hit_ihit", {31'b0, ihit}, 32'd1);
    chk("hit_iren", {31'b0, iREN}, 32'd0);
    if (ihit === 1'b1 && sb.size() > 0) begin
      exp = sb.pop_front();
      chk("hit_data", imemload, exp);
      exp_hit++;
    end
    @(posedge CLK); #1;
    imemREN = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    nRST = 1'b0; imemREN = 1'b0; imemaddr = '0; halt = 1'b0; iwait = 1'b1; iload = '0;
    #2;
    chk("rst_ihit", {31'b0, ihit}, 32'd0);
    chk("rst_imemload", imemload, 32'd0);
    chk("rst_iren", {31'b0, iREN}, 32'd0);
    chk("rst_iaddr", iaddr, 32'd0);
    check_counts("rst");
    @(posedge CLK); @(posedge CLK); #1;
    nRST = 1'b1;
    @(posedge CLK); #1;

    // First fetch: minimum miss penalty, then hit.
    fetch(32'h0000_0040, 1'b1, 0);
    check_counts("first");
    fetch(32'h0000_0040, 1'b0, 0);

    // Conflict on index 0.
    fetch(32'h0000_0080, 1'b1, 0);
    fetch(32'h0000_0040, 1'b1, 0);
    check_counts("conflict");
    chk("conflict_misses3", miss_count, 32'd3);

    // Slow memory: five wait cycles, six FETCH cycles.
    fetch(32'h0000_00C4, 1'b1, 5);
    check_counts("slow");

    // Redirect during FETCH: 0x104 (index 1) still fills, then 0x208 (index 2) misses.
    imemREN = 1'b1; imemaddr = 32'h0000_0104; iwait = 1'b1;
    @(negedge CLK);
    chk("redir_detect_ihit", {31'b0, ihit}, 32'd0);
    @(posedge CLK); #1;
    iload = 32'hDEAD_BEEF;
    @(negedge CLK);
    chk("redir_iren", {31'b0, iREN}, 32'd1);
    @(posedge CLK); #1;
    imemaddr = 32'h0000_0208; iwait = 1'b0; iload = memword(iaddr);
    @(negedge CLK);
    chk("redir_iaddr_latched", iaddr, 32'h0000_0104);
    chk("redir_ihit", {31'b0, ihit}, 32'd0);
    @(posedge CLK); #1;
    iwait = 1'b1;
    exp_miss++;
    fetch(32'h0000_0208, 1'b1, 0);
    fetch(32'h0000_0104, 1'b0, 0);
    check_counts("redir");

    // Halt with a resident address.
    imemREN = 1'b1; imemaddr = 32'h0000_0104; halt = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      chk("halt_ihit", {31'b0, ihit}, 32'd0);
      chk("halt_iren", {31'b0, iREN}, 32'd0);
      @(posedge CLK); #1;
    end
    check_counts("halt");
    imemREN = 1'b0; halt = 1'b0;

    // Reset mid-FETCH.
    imemREN = 1'b1; imemaddr = 32'h0000_030C; iwait = 1'b1;
    @(posedge CLK); #1;
    @(negedge CLK);
    chk("prerst_iren", {31'b0, iREN}, 32'd1);
    #1;
    nRST = 1'b0;
    #1;
    chk("midrst_iren", {31'b0, iREN}, 32'd0);
    chk("midrst_iaddr", iaddr, 32'd0);
    exp_hit = '0; exp_miss = '0;
    check_counts("midrst");
    imemREN = 1'b0;
    @(posedge CLK); #1;
    nRST = 1'b1;
    @(posedge CLK); #1;
    fetch(32'h0000_0040, 1'b1, 0);
    fetch(32'h0000_0104, 1'b1, 0);
    check_counts("postrst");

    chk("sb_empty", sb.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
